xif_issue_arbiter: RTL and testbench
====================================

# xif_issue_arbiter

Shares one CORE-V-XIF coprocessor between NUM_REQ CPU-side X-IF requesters, such as several CV32E20 cores or a core plus a DMA-style issuer. It sits between the cores' X-IF issue/commit/result ports and the single coprocessor port. The block grants one requester at a time, round-robin, and sequences the transaction issue → commit → result. It routes the handshakes and responses back to the granted requester only. At most one coprocessor instruction is outstanding.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_WIDTH, 4, X-IF instruction id width.

Ports (per-requester vectors are packed, index r = requester):
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_issue_valid_i  in  NUM_REQ  issue request valid
- req_issue_ready_o  out  NUM_REQ  issue ready, granted requester only
- req_instr_i  in  NUM_REQ×32  instruction word
- req_id_i  in  NUM_REQ×ID_WIDTH  instruction id
- req_rs_i  in  NUM_REQ×2×32  source operands rs0, rs1
- req_rs_valid_i  in  NUM_REQ×2  operand valid flags
- req_accept_o, req_writeback_o  out  NUM_REQ  issue response
- req_commit_valid_i  in  NUM_REQ  commit valid
- req_commit_id_i  in  NUM_REQ×ID_WIDTH  commit id
- req_commit_kill_i  in  NUM_REQ  commit kill
- req_result_valid_o  out  NUM_REQ  result valid
- req_result_ready_i  in  NUM_REQ  result ready
- req_result_data_o  out  32  result data, broadcast to all requesters
- req_result_rd_o  out  5  result destination register, broadcast
- req_result_we_o  out  1  result write enable, broadcast
- req_result_id_o  out  ID_WIDTH  result id, broadcast
- cp_issue_valid_o / cp_issue_ready_i  out/in  1  coprocessor issue handshake
- cp_instr_o, cp_id_o, cp_rs_o, cp_rs_valid_o  out  32, ID_WIDTH, 2×32, 2  muxed issue fields
- cp_accept_i, cp_writeback_i  in  1  issue response
- cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o  out  1, ID_WIDTH, 1  commit
- cp_result_valid_i / cp_result_ready_o  in/out  1  result handshake
- cp_result_data_i, cp_result_rd_i, cp_result_we_i, cp_result_id_i  in  32, 5, 1, ID_WIDTH
- busy_o  out  1  state ≠ IDLE
- grant_o  out  $clog2(NUM_REQ)  current or last grant index

## Operation
- FSM states: IDLE, ISSUE, WAIT_COMMIT, WAIT_RESULT.
- **IDLE:**
  - If any req_issue_valid_i is set, choose the first set requester starting at rr_ptr and searching upward with wrap.
  - Register the winner in grant_q and go to ISSUE.
  - All outputs to requesters and the coprocessor are inactive.
- **ISSUE:**
  - cp_issue_valid_o equals req_issue_valid_i[grant_q]; the issue fields are muxed from grant_q.
  - req_issue_ready_o[grant_q] equals cp_issue_ready_i; every other ready bit is 0.
  - cp_accept_i and cp_writeback_i are forwarded to grant_q during the handshake cycle. The writeback value is latched in wb_q.
  - If the granted requester drops valid before the handshake, return to IDLE with rr_ptr unchanged.
  - On handshake with accept=0: go to IDLE and set rr_ptr = grant_q+1.
  - On handshake with accept=1: go to WAIT_COMMIT.
  - A commit from grant_q in the same cycle as the handshake is forwarded and handled as in WAIT_COMMIT.
- **WAIT_COMMIT:**
  - cp_commit_* is driven from grant_q.
  - On commit_valid: if kill=1 or wb_q=0, go to IDLE and advance rr_ptr; otherwise go to WAIT_RESULT.
- **WAIT_RESULT:**
  - req_result_valid_o[grant_q] equals cp_result_valid_i.
  - cp_result_ready_o equals req_result_ready_i[grant_q].
  - On result handshake: go to IDLE and advance rr_ptr.
- Commits and result-readies from non-granted requesters are ignored and never forwarded.
- rr_ptr wraps: rr_ptr = (grant_q == NUM_REQ-1) ? 0 : grant_q+1.

## Timing
- Reset: state IDLE, rr_ptr 0, grant_q 0, wb_q 0. All *_valid_o, *_ready_o, accept, writeback, kill and busy_o are 0.
- Arbitration latency is one cycle: valid seen in IDLE means cp_issue_valid_o is asserted the next cycle.
- All coprocessor-side and requester-side outputs in ISSUE, WAIT_COMMIT and WAIT_RESULT are combinational from grant_q and the inputs. There is no added latency.
- Minimum transaction length:
  - accept=0: 2 cycles.
  - accept=1, writeback=0, commit in the handshake cycle: 2 cycles.
  - writeback with an immediate result: 3 cycles.
- Back-to-back: after returning to IDLE, the next grant follows one cycle later.
- Reset asserted in any state returns to IDLE in the next cycle and deasserts all valids. The coprocessor shares rst_i.

## Test plan
1. Single request, full path:
   - Stimulus: req0 issues instr 0x0000_500B with id 3; coprocessor answers accept=1, writeback=1; req0 commits with kill=0; coprocessor returns result data 0xDEAD_BEEF, rd=5.
   - Required response: only req_result_valid_o[0] pulses, carrying 0xDEAD_BEEF and rd 5. State returns to IDLE and rr_ptr becomes 1.
2. Round robin:
   - Stimulus: req0 and req1 hold issue valid continuously; every transaction has accept=0.
   - Required response: grant_o sequence is 0,1,0,1. The non-granted requester's req_issue_ready_o is always 0.
3. Reject:
   - Stimulus: coprocessor answers accept=0.
   - Required response: req_accept_o[g]=0, no cp_commit_valid_o, IDLE after 2 cycles.
4. Kill:
   - Stimulus: accept=1, writeback=1, then commit with kill=1.
   - Required response: cp_commit_kill_o=1, IDLE with no result phase. A later stray cp_result_valid_i is not forwarded.
5. Same-cycle commit and foreign commit:
   - Stimulus: req1 asserts commit together with the issue handshake, with writeback=0. req0 asserts commit_valid in the same cycle.
   - Required response: IDLE next cycle; cp_commit_id_o equals req1's id; req0's commit is ignored.
6. Reset mid-transaction:
   - Stimulus: rst_i asserted while in WAIT_RESULT.
   - Required response: next cycle all valid and ready outputs are 0, busy_o=0, grant_o=0.

Source files
------------

// File: rtl/xif_issue_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xif_issue_arbiter_if : requester-side and coprocessor-side X-IF bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface xif_issue_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 4
);
  logic [NUM_REQ-1:0]                 req_issue_valid_i;
  logic [NUM_REQ-1:0]                 req_issue_ready_o;
  logic [NUM_REQ-1:0][31:0]           req_instr_i;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   req_id_i;
  logic [NUM_REQ-1:0][1:0][31:0]      req_rs_i;
  logic [NUM_REQ-1:0][1:0]            req_rs_valid_i;
  logic [NUM_REQ-1:0]                 req_accept_o;
  logic [NUM_REQ-1:0]                 req_writeback_o;
  logic [NUM_REQ-1:0]                 req_commit_valid_i;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   req_commit_id_i;
  logic [NUM_REQ-1:0]                 req_commit_kill_i;
  logic [NUM_REQ-1:0]                 req_result_valid_o;
  logic [NUM_REQ-1:0]                 req_result_ready_i;
  logic [31:0]                        req_result_data_o;
  logic [4:0]                         req_result_rd_o;
  logic                               req_result_we_o;
  logic [ID_WIDTH-1:0]                req_result_id_o;

  logic                               cp_issue_valid_o;
  logic                               cp_issue_ready_i;
  logic [31:0]                        cp_instr_o;
  logic [ID_WIDTH-1:0]                cp_id_o;
  logic [1:0][31:0]                   cp_rs_o;
  logic [1:0]                         cp_rs_valid_o;
  logic                               cp_accept_i;
  logic                               cp_writeback_i;
  logic                               cp_commit_valid_o;
  logic [ID_WIDTH-1:0]                cp_commit_id_o;
  logic                               cp_commit_kill_o;
  logic                               cp_result_valid_i;
  logic                               cp_result_ready_o;
  logic [31:0]                        cp_result_data_i;
  logic [4:0]                         cp_result_rd_i;
  logic                               cp_result_we_i;
  logic [ID_WIDTH-1:0]                cp_result_id_i;

  modport master (
    input  req_issue_valid_i, req_instr_i, req_id_i, req_rs_i, req_rs_valid_i,
           req_commit_valid_i, req_commit_id_i, req_commit_kill_i, req_result_ready_i,
           cp_issue_ready_i, cp_accept_i, cp_writeback_i, cp_result_valid_i,
           cp_result_data_i, cp_result_rd_i, cp_result_we_i, cp_result_id_i,
    output req_issue_ready_o, req_accept_o, req_writeback_o, req_result_valid_o,
           req_result_data_o, req_result_rd_o, req_result_we_o, req_result_id_o,
           cp_issue_valid_o, cp_instr_o, cp_id_o, cp_rs_o, cp_rs_valid_o,
           cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o
  );

  modport slave (
    output req_issue_valid_i, req_instr_i, req_id_i, req_rs_i, req_rs_valid_i,
           req_commit_valid_i, req_commit_id_i, req_commit_kill_i, req_result_ready_i,
           cp_issue_ready_i, cp_accept_i, cp_writeback_i, cp_result_valid_i,
           cp_result_data_i, cp_result_rd_i, cp_result_we_i, cp_result_id_i,
    input  req_issue_ready_o, req_accept_o, req_writeback_o, req_result_valid_o,
           req_result_data_o, req_result_rd_o, req_result_we_o, req_result_id_o,
           cp_issue_valid_o, cp_instr_o, cp_id_o, cp_rs_o, cp_rs_valid_o,
           cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/xif_issue_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xif_issue_arbiter : round-robin sharing of one X-IF coprocessor, one op in flight
// Rev 1.0
// ----------------------------------------------------------------------------
module xif_issue_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 4
) (
  input  wire logic                         clk_i,
  input  wire logic                         rst_i,
  xif_issue_arbiter_if.master               xif,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        grant_o
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ISSUE       = 2'd1,
    S_WAIT_COMMIT = 2'd2,
    S_WAIT_RESULT = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_rr_ptr, w_rr_nxt;
  logic            r_wb, w_wb_nxt;
  logic [GW-1:0]   w_pick, w_ptr_adv;
  logic            w_any;
  logic            w_gv, w_commit, w_kill;
  int              w_idx;

  assign w_gv      = xif.req_issue_valid_i[r_grant];
  assign w_commit  = xif.req_commit_valid_i[r_grant];
  assign w_kill    = xif.req_commit_kill_i[r_grant];
  assign w_ptr_adv = (r_grant == GW'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
  assign busy_o    = (r_state != S_IDLE);
  assign grant_o   = r_grant;

  // Descending scan so the last hit is the first requester at/after r_rr_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_idx  = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (xif.req_issue_valid_i[w_idx]) begin
        w_any  = 1'b1;
        w_pick = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt               = r_state;
    w_grant_nxt               = r_grant;
    w_rr_nxt                  = r_rr_ptr;
    w_wb_nxt                  = r_wb;
    xif.req_issue_ready_o     = '0;
    xif.req_accept_o          = '0;
    xif.req_writeback_o       = '0;
    xif.req_result_valid_o    = '0;
    xif.req_result_data_o     = '0;
    xif.req_result_rd_o       = '0;
    xif.req_result_we_o       = 1'b0;
    xif.req_result_id_o       = '0;
    xif.cp_issue_valid_o      = 1'b0;
    xif.cp_instr_o            = '0;
    xif.cp_id_o               = '0;
    xif.cp_rs_o               = '0;
    xif.cp_rs_valid_o         = '0;
    xif.cp_commit_valid_o     = 1'b0;
    xif.cp_commit_id_o        = '0;
    xif.cp_commit_kill_o      = 1'b0;
    xif.cp_result_ready_o     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        xif.cp_issue_valid_o           = w_gv;
        xif.cp_instr_o                 = xif.req_instr_i[r_grant];
        xif.cp_id_o                    = xif.req_id_i[r_grant];
        xif.cp_rs_o                    = xif.req_rs_i[r_grant];
        xif.cp_rs_valid_o              = xif.req_rs_valid_i[r_grant];
        xif.req_issue_ready_o[r_grant] = xif.cp_issue_ready_i;
        if (!w_gv) begin
          // Withdrawn request: the same requester keeps priority.
          w_state_nxt = S_IDLE;
        end else if (xif.cp_issue_ready_i) begin
          xif.req_accept_o[r_grant]    = xif.cp_accept_i;
          xif.req_writeback_o[r_grant] = xif.cp_writeback_i;
          w_wb_nxt                     = xif.cp_writeback_i;
          if (!xif.cp_accept_i) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = w_ptr_adv;
          end else if (w_commit) begin
            xif.cp_commit_valid_o = 1'b1;
            xif.cp_commit_id_o    = xif.req_commit_id_i[r_grant];
            xif.cp_commit_kill_o  = w_kill;
            if (w_kill || !xif.cp_writeback_i) begin
              w_state_nxt = S_IDLE;
              w_rr_nxt    = w_ptr_adv;
            end else begin
              w_state_nxt = S_WAIT_RESULT;
            end
          end else begin
            w_state_nxt = S_WAIT_COMMIT;
          end
        end
      end

      S_WAIT_COMMIT: begin
        xif.cp_commit_valid_o = w_commit;
        xif.cp_commit_id_o    = xif.req_commit_id_i[r_grant];
        xif.cp_commit_kill_o  = w_commit & w_kill;
        if (w_commit) begin
          if (w_kill || !r_wb) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = w_ptr_adv;
          end else begin
            w_state_nxt = S_WAIT_RESULT;
          end
        end
      end

      S_WAIT_RESULT: begin
        xif.req_result_valid_o[r_grant] = xif.cp_result_valid_i;
        xif.cp_result_ready_o           = xif.req_result_ready_i[r_grant];
        xif.req_result_data_o           = xif.cp_result_data_i;
        xif.req_result_rd_o             = xif.cp_result_rd_i;
        xif.req_result_we_o             = xif.cp_result_we_i;
        xif.req_result_id_o             = xif.cp_result_id_i;
        if (xif.cp_result_valid_i && xif.req_result_ready_i[r_grant]) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_ptr_adv;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_wb     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_wb     <= w_wb_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_xif_issue_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xif_issue_arbiter : directed scenarios plus randomized transactions vs. model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_xif_issue_arbiter;
  localparam int N  = 3;
  localparam int IW = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       busy_o;
  logic [1:0] grant_o;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;

  xif_issue_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IW)) xif ();

  xif_issue_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .xif     (xif.master),
    .busy_o  (busy_o),
    .grant_o (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Every handshake/response output that must be low when nothing is in flight.
  task automatic quiet(input string tag);
    chk(tag, 64'({busy_o, xif.cp_issue_valid_o, xif.req_issue_ready_o, xif.req_accept_o,
                  xif.req_writeback_o, xif.cp_commit_valid_o, xif.cp_commit_kill_o,
                  xif.req_result_valid_o, xif.cp_result_ready_o}), 64'd0);
  endtask

  task automatic clear_inputs();
    xif.req_issue_valid_i  = '0;
    xif.req_instr_i        = '0;
    xif.req_id_i           = '0;
    xif.req_rs_i           = '0;
    xif.req_rs_valid_i     = '0;
    xif.req_commit_valid_i = '0;
    xif.req_commit_id_i    = '0;
    xif.req_commit_kill_i  = '0;
    xif.req_result_ready_i = '0;
    xif.cp_issue_ready_i   = 1'b0;
    xif.cp_accept_i        = 1'b0;
    xif.cp_writeback_i     = 1'b0;
    xif.cp_result_valid_i  = 1'b0;
    xif.cp_result_data_i   = '0;
    xif.cp_result_rd_i     = '0;
    xif.cp_result_we_i     = 1'b0;
    xif.cp_result_id_i     = '0;
  endtask

  // Round-robin rule: first requesting index at or after the pointer, wrapping.
  function automatic int exp_grant(input logic [N-1:0] mask, input int rr);
    for (int k = 0; k < N; k++)
      if (mask[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic rand_txn(input int t);
    logic [31:0]   instr [N];
    logic [IW-1:0] id    [N];
    logic [IW-1:0] cid   [N];
    logic [63:0]   rsv   [N];
    logic [1:0]    rsvld [N];
    logic [N-1:0]  mask, gm, rdy;
    logic [31:0]   data;
    int            g, w;
    bit            acc, wb, same, kill;

    mask = N'($urandom_range(1, (1 << N) - 1));
    for (int r = 0; r < N; r++) begin
      instr[r] = $urandom;
      id[r]    = IW'($urandom);
      cid[r]   = IW'($urandom);
      rsv[r]   = {$urandom, $urandom};
      rsvld[r] = 2'($urandom);
      xif.req_instr_i[r]     = instr[r];
      xif.req_id_i[r]        = id[r];
      xif.req_commit_id_i[r] = cid[r];
      xif.req_rs_i[r]        = rsv[r];
      xif.req_rs_valid_i[r]  = rsvld[r];
    end
    xif.req_issue_valid_i = mask;
    settle();
    quiet($sformatf("r%0d_idle", t));
    g  = exp_grant(mask, m_rr);
    gm = N'(1 << g);
    tick();

    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      xif.cp_issue_ready_i = 1'b0;
      settle();
      chk($sformatf("r%0d_stall_grant", t), 64'(grant_o), 64'(g));
      chk($sformatf("r%0d_stall_rdy", t), 64'({xif.cp_issue_valid_o, xif.req_issue_ready_o}),
          64'({1'b1, N'(0)}));
      tick();
    end

    if ($urandom_range(0, 7) == 0) begin
      // Requester withdraws before any handshake; pointer must not move.
      xif.req_issue_valid_i = '0;
      xif.cp_issue_ready_i  = 1'b1;
      settle();
      chk($sformatf("r%0d_drop", t), 64'({xif.cp_issue_valid_o, xif.req_issue_ready_o}),
          64'({1'b0, gm}));
      tick();
    end else begin
      acc  = ($urandom_range(0, 3) != 0);
      wb   = 1'($urandom);
      same = 1'($urandom);
      kill = ($urandom_range(0, 3) == 0);
      xif.cp_issue_ready_i   = 1'b1;
      xif.cp_accept_i        = acc;
      xif.cp_writeback_i     = wb;
      xif.req_commit_valid_i = same ? (N'($urandom) | gm) : (N'($urandom) & ~gm);
      xif.req_commit_kill_i  = kill ? (N'($urandom) | gm) : (N'($urandom) & ~gm);
      settle();
      chk($sformatf("r%0d_grant", t), 64'(grant_o), 64'(g));
      chk($sformatf("r%0d_instr", t), 64'({xif.cp_issue_valid_o, xif.cp_id_o, xif.cp_instr_o}),
          64'({1'b1, id[g], instr[g]}));
      chk($sformatf("r%0d_rs", t), 64'(xif.cp_rs_o), rsv[g]);
      chk($sformatf("r%0d_rsv", t), 64'(xif.cp_rs_valid_o), 64'(rsvld[g]));
      chk($sformatf("r%0d_resp", t),
          64'({xif.req_issue_ready_o, xif.req_accept_o, xif.req_writeback_o}),
          64'({gm, acc ? gm : N'(0), wb ? gm : N'(0)}));
      chk($sformatf("r%0d_hs_commit", t), 64'(xif.cp_commit_valid_o), 64'(acc && same));
      if (acc && same)
        chk($sformatf("r%0d_hs_cid", t), 64'({xif.cp_commit_kill_o, xif.cp_commit_id_o}),
            64'({kill, cid[g]}));
      tick();
      xif.req_issue_valid_i = '0;
      xif.cp_issue_ready_i  = 1'b0;
      xif.req_commit_valid_i = '0;

      if (acc) begin
        if (!same) begin
          w = $urandom_range(0, 2);
          for (int i = 0; i < w; i++) begin
            xif.req_commit_valid_i = N'($urandom) & ~gm;
            xif.req_commit_kill_i  = N'($urandom);
            settle();
            chk($sformatf("r%0d_foreign", t), 64'({busy_o, xif.cp_commit_valid_o, xif.cp_commit_kill_o}),
                64'(3'b100));
            tick();
          end
          kill = ($urandom_range(0, 3) == 0);
          xif.req_commit_valid_i = N'($urandom) | gm;
          xif.req_commit_kill_i  = kill ? (N'($urandom) | gm) : (N'($urandom) & ~gm);
          settle();
          chk($sformatf("r%0d_commit", t),
              64'({xif.cp_commit_valid_o, xif.cp_commit_kill_o, xif.cp_commit_id_o}),
              64'({1'b1, kill, cid[g]}));
          tick();
          xif.req_commit_valid_i = '0;
        end
        if (wb && !kill) begin
          w = $urandom_range(0, 2);
          for (int i = 0; i < w; i++) begin
            rdy = N'($urandom);
            xif.req_result_ready_i = rdy;
            xif.cp_result_valid_i  = 1'b0;
            settle();
            chk($sformatf("r%0d_rwait", t), 64'({busy_o, xif.req_result_valid_o, xif.cp_result_ready_o}),
                64'({1'b1, N'(0), rdy[g]}));
            tick();
          end
          for (int a = 0; a < 3; a++) begin
            data = $urandom;
            rdy  = (a == 2) ? (N'($urandom) | gm) : N'($urandom);
            xif.req_result_ready_i = rdy;
            xif.cp_result_valid_i  = 1'b1;
            xif.cp_result_data_i   = data;
            settle();
            chk($sformatf("r%0d_result", t),
                64'({xif.req_result_valid_o, xif.cp_result_ready_o, xif.req_result_data_o}),
                64'({gm, rdy[g], data}));
            tick();
            if (rdy[g]) break;
          end
        end
      end
      m_rr = (g + 1) % N;
    end
    clear_inputs();
    settle();
    quiet($sformatf("r%0d_done", t));
  endtask

  initial begin
    int seq [5];
    seq = '{1, 0, 1, 0, 1};

    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    quiet("reset_quiet");
    chk("reset_grant", 64'(grant_o), 64'd0);

    // Single request, full path.
    xif.req_issue_valid_i = 3'b001;
    xif.req_instr_i[0]    = 32'h0000_500B;
    xif.req_id_i[0]       = 4'd3;
    xif.req_rs_i[0]       = {32'h2222_2222, 32'h1111_1111};
    xif.req_rs_valid_i[0] = 2'b11;
    settle();
    quiet("t1_idle");
    tick();
    xif.cp_issue_ready_i = 1'b1;
    xif.cp_accept_i      = 1'b1;
    xif.cp_writeback_i   = 1'b1;
    settle();
    chk("t1_issue", 64'({xif.cp_issue_valid_o, xif.cp_id_o, xif.cp_instr_o}),
        64'({1'b1, 4'd3, 32'h0000_500B}));
    chk("t1_resp", 64'({xif.req_issue_ready_o, xif.req_accept_o, xif.req_writeback_o}),
        64'({3'b001, 3'b001, 3'b001}));
    tick();
    clear_inputs();
    xif.req_commit_valid_i = 3'b001;
    xif.req_commit_id_i[0] = 4'd3;
    settle();
    chk("t1_commit", 64'({xif.cp_commit_valid_o, xif.cp_commit_kill_o, xif.cp_commit_id_o}),
        64'({1'b1, 1'b0, 4'd3}));
    tick();
    clear_inputs();
    xif.cp_result_valid_i  = 1'b1;
    xif.cp_result_data_i   = 32'hDEAD_BEEF;
    xif.cp_result_rd_i     = 5'd5;
    xif.cp_result_we_i     = 1'b1;
    xif.cp_result_id_i     = 4'd3;
    xif.req_result_ready_i = 3'b111;
    settle();
    chk("t1_result", 64'({xif.req_result_valid_o, xif.cp_result_ready_o, xif.req_result_rd_o,
                          xif.req_result_data_o}), 64'({3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF}));
    tick();
    clear_inputs();
    settle();
    quiet("t1_done");
    m_rr = 1;

    // Round robin with continuous requests, every issue rejected.
    for (int i = 0; i < 5; i++) begin
      xif.req_issue_valid_i = 3'b011;
      xif.cp_issue_ready_i  = 1'b0;
      xif.cp_accept_i       = 1'b0;
      settle();
      quiet($sformatf("rr%0d_idle", i));
      tick();
      xif.cp_issue_ready_i = 1'b1;
      settle();
      chk($sformatf("rr%0d_grant", i), 64'(grant_o), 64'(seq[i]));
      chk($sformatf("rr%0d_rdy", i), 64'({xif.req_issue_ready_o, xif.req_accept_o, xif.cp_commit_valid_o}),
          64'({3'(1 << seq[i]), 3'b000, 1'b0}));
      tick();
    end
    clear_inputs();
    settle();
    quiet("rr_done");
    m_rr = 2;

    // Kill: no result phase, stray result not forwarded.
    xif.req_issue_valid_i = 3'b100;
    xif.req_id_i[2]       = 4'd7;
    tick();
    xif.cp_issue_ready_i = 1'b1;
    xif.cp_accept_i      = 1'b1;
    xif.cp_writeback_i   = 1'b1;
    settle();
    chk("t4_grant", 64'(grant_o), 64'd2);
    tick();
    clear_inputs();
    xif.req_commit_valid_i = 3'b100;
    xif.req_commit_kill_i  = 3'b100;
    xif.req_commit_id_i[2] = 4'd7;
    settle();
    chk("t4_kill", 64'({xif.cp_commit_valid_o, xif.cp_commit_kill_o, xif.cp_commit_id_o}),
        64'({1'b1, 1'b1, 4'd7}));
    tick();
    clear_inputs();
    xif.cp_result_valid_i  = 1'b1;
    xif.req_result_ready_i = 3'b111;
    settle();
    quiet("t4_stray");
    clear_inputs();
    m_rr = 0;

    // Same-cycle commit from req1 with a foreign commit from req0.
    xif.req_issue_valid_i = 3'b010;
    tick();
    xif.cp_issue_ready_i   = 1'b1;
    xif.cp_accept_i        = 1'b1;
    xif.cp_writeback_i     = 1'b0;
    xif.req_commit_valid_i = 3'b011;
    xif.req_commit_id_i[0] = 4'hA;
    xif.req_commit_kill_i  = 3'b001;
    xif.req_commit_id_i[1] = 4'd9;
    settle();
    chk("t5_commit", 64'({grant_o, xif.cp_commit_valid_o, xif.cp_commit_kill_o, xif.cp_commit_id_o}),
        64'({2'd1, 1'b1, 1'b0, 4'd9}));
    tick();
    clear_inputs();
    settle();
    quiet("t5_idle");
    m_rr = 2;

    // Reset while waiting on a result.
    xif.req_issue_valid_i = 3'b100;
    tick();
    xif.cp_issue_ready_i   = 1'b1;
    xif.cp_accept_i        = 1'b1;
    xif.cp_writeback_i     = 1'b1;
    xif.req_commit_valid_i = 3'b100;
    tick();
    clear_inputs();
    xif.cp_result_valid_i = 1'b1;
    settle();
    chk("t6_wait", 64'({busy_o, xif.req_result_valid_o, xif.cp_result_ready_o}), 64'({1'b1, 3'b100, 1'b0}));
    rst_i = 1'b1;
    tick();
    xif.req_result_ready_i = 3'b111;
    xif.req_issue_valid_i  = 3'b100;
    settle();
    quiet("t6_quiet");
    chk("t6_grant", 64'(grant_o), 64'd0);
    rst_i = 1'b0;
    clear_inputs();
    m_rr = 0;

    for (int t = 0; t < 60; t++)
      rand_txn(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
